// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the EX-to-multiplier issue controller: opcode
// encodings (shared with the shift-add multiplier), widths and state encoding.
package mul_issue_ctrl_pkg;

  localparam int unsigned XLEN_DEF        = 64;
  localparam int unsigned CYCLE_LIMIT_DEF = 72;
  localparam int unsigned CNT_W_DEF       = 7;
  localparam int unsigned OPF3_W          = 10;
  localparam int unsigned RD_W            = 5;

  // {opcode[6:0], funct3}
  localparam logic [OPF3_W-1:0] INST_MUL    = 10'b0110011000;
  localparam logic [OPF3_W-1:0] INST_MULH   = 10'b0110011001;
  localparam logic [OPF3_W-1:0] INST_MULHSU = 10'b0110011010;
  localparam logic [OPF3_W-1:0] INST_MULHU  = 10'b0110011011;
  localparam logic [OPF3_W-1:0] INST_MULW   = 10'b0111011000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_mul_opcode(input logic [OPF3_W-1:0] op_f3);
    case (op_f3)
      INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU, INST_MULW: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_op_classify.sv
// Combinational request classifier: supported M-extension multiply opcode,
// and zero-operand bypass (product is known to be zero without the multiplier).
module mul_op_classify
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [OPF3_W-1:0] op_f3_i,
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  output logic              is_mul_op_c,
  output logic              zero_bypass_c
);

  assign is_mul_op_c   = is_mul_opcode(op_f3_i);
  assign zero_bypass_c = (op1_i == '0) || (op2_i == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequencing controller between EX and the iterative multiplier: accepts one
// request, runs the multiplier with a watchdog, and returns the product.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned CYCLE_LIMIT = CYCLE_LIMIT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPF3_W-1:0] req_op_f3,
  input  logic [XLEN-1:0]   req_op1,
  input  logic [XLEN-1:0]   req_op2,
  input  logic [RD_W-1:0]   req_rd,
  input  logic              flush,
  output logic              busy_o,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_err,
  output logic              mul_start,
  output logic [OPF3_W-1:0] mul_op_f3,
  output logic [XLEN-1:0]   mul_op1,
  output logic [XLEN-1:0]   mul_op2,
  input  logic [XLEN-1:0]   mul_product,
  input  logic              mul_finish
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OPF3_W-1:0]   op_f3_q, op_f3_d;
  logic [XLEN-1:0]     op1_q, op1_d;
  logic [XLEN-1:0]     op2_q, op2_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [XLEN-1:0]     resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  logic                is_mul_op_c;
  logic                zero_bypass_c;
  logic                accept_c;
  logic                finish_seen_c;
  logic                watchdog_c;

  mul_op_classify #(
    .XLEN (XLEN)
  ) u_classify (
    .op_f3_i       (req_op_f3),
    .op1_i         (req_op1),
    .op2_i         (req_op2),
    .is_mul_op_c   (is_mul_op_c),
    .zero_bypass_c (zero_bypass_c)
  );

  assign accept_c      = req_valid && req_ready;
  // The first RUN cycle is the multiplier's load cycle; a finish there is stale.
  assign finish_seen_c = mul_finish && (cnt_q != '0);
  assign watchdog_c    = (cnt_q == CNT_W'(CYCLE_LIMIT - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_f3_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_f3_q     <= op_f3_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_f3_d     = op_f3_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_f3_d = req_op_f3;
          op1_d   = req_op1;
          op2_d   = req_op2;
          rd_d    = req_rd;
          if (!is_mul_op_c) begin
            state_d     = ST_DONE;
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end else if (zero_bypass_c) begin
            state_d     = ST_DONE;
            resp_data_d = '0;
            resp_err_d  = 1'b0;
          end else begin
            state_d    = ST_RUN;
            cnt_d      = '0;
            resp_err_d = 1'b0;
          end
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Flush outranks a finish arriving in the same cycle.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (finish_seen_c) begin
          state_d     = ST_DONE;
          resp_data_d = mul_product;
          resp_err_d  = 1'b0;
        end else if (watchdog_c) begin
          state_d     = ST_DONE;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
        end
      end

      ST_DONE: begin
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decodes of registered state or registered datapath values.
  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign busy_o     = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign mul_start  = (state_q == ST_RUN);
  assign resp_data  = resp_data_q;
  assign resp_rd    = rd_q;
  assign resp_err   = resp_err_q;
  assign mul_op_f3  = op_f3_q;
  assign mul_op1    = op1_q;
  assign mul_op2    = op2_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: a behavioural multiplier stub plus a
// transaction-level reference (expected result, error flag and latency).
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned CYCLE_LIMIT = 72;
  localparam int          WAIT_MAX    = 200;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [9:0]        req_op_f3;
  logic [XLEN-1:0]   req_op1;
  logic [XLEN-1:0]   req_op2;
  logic [4:0]        req_rd;
  logic              flush;
  logic              busy_o;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic [4:0]        resp_rd;
  logic              resp_err;
  logic              mul_start;
  logic [9:0]        mul_op_f3;
  logic [XLEN-1:0]   mul_op1;
  logic [XLEN-1:0]   mul_op2;
  logic [XLEN-1:0]   mul_product;
  logic              mul_finish;

  int n_cmp = 0;
  int n_bad = 0;

  // Multiplier stub configuration
  int stub_lat    = 1;
  bit stub_en     = 1'b1;
  bit stub_glitch = 1'b0;
  int run_idx     = 0;
  bit prev_start  = 1'b0;

  mul_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op_f3   (req_op_f3),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_rd      (req_rd),
    .flush       (flush),
    .busy_o      (busy_o),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_rd     (resp_rd),
    .resp_err    (resp_err),
    .mul_start   (mul_start),
    .mul_op_f3   (mul_op_f3),
    .mul_op1     (mul_op1),
    .mul_op2     (mul_op2),
    .mul_product (mul_product),
    .mul_finish  (mul_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [9:0] f, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] xa, xb, p;
    xa = {64'd0, a};
    xb = {64'd0, b};
    if (f == INST_MULH || f == INST_MULHSU) xa = {{64{a[63]}}, a};
    if (f == INST_MULH) xb = {{64{b[63]}}, b};
    if (f == INST_MULW) begin
      xa = {96'd0, a[31:0]};
      xb = {96'd0, b[31:0]};
    end
    p = xa * xb;
    if (f == INST_MUL) return p[63:0];
    if (f == INST_MULW) return {{32{p[31]}}, p[31:0]};
    if (f == INST_MULH || f == INST_MULHSU || f == INST_MULHU) return p[127:64];
    return 64'd0;
  endfunction

  function automatic bit op_supported(input logic [9:0] f);
    return (f == INST_MUL) || (f == INST_MULH) || (f == INST_MULHSU) ||
           (f == INST_MULHU) || (f == INST_MULW);
  endfunction

  function automatic int msb_pos(input logic [63:0] v);
    int p = 0;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    return p;
  endfunction

  // Shift-add multiplier stub: finishes `stub_lat` cycles after its load cycle.
  always @(negedge clk) begin
    if (mul_start) run_idx = prev_start ? run_idx + 1 : 0;
    prev_start  = mul_start;
    mul_finish  = mul_start && stub_en &&
                  ((run_idx == stub_lat) || (stub_glitch && run_idx == 0));
    mul_product = ref_mul(mul_op_f3, mul_op1, mul_op2);
  end

  task automatic accept(input logic [9:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd);
    @(negedge clk);
    chk("req_ready_pre", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op_f3 = f;
    req_op1   = a;
    req_op2   = b;
    req_rd    = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_op_f3 = 10'($urandom);
    req_op1   = {$urandom, $urandom};
    req_op2   = {$urandom, $urandom};
    req_rd    = 5'($urandom);
  endtask

  task automatic do_op(input logic [9:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input int hold, input bit glitch, input bit en);
    logic [63:0] exp_d;
    bit exp_e, started;
    int exp_lat, n;
    stub_lat    = msb_pos(b) + 1;
    stub_glitch = glitch;
    stub_en     = en;
    if (!op_supported(f)) begin
      exp_d = 0; exp_e = 1; exp_lat = 1;
    end else if (a == 0 || b == 0) begin
      exp_d = 0; exp_e = 0; exp_lat = 1;
    end else if (!en) begin
      exp_d = 0; exp_e = 1; exp_lat = 1 + CYCLE_LIMIT;
    end else begin
      exp_d = ref_mul(f, a, b); exp_e = 0; exp_lat = stub_lat + 2;
    end
    resp_ready = 1'b0;
    accept(f, a, b, rd);
    n = 1;
    started = mul_start;
    while (!resp_valid && n < WAIT_MAX) begin
      chk("busy_run", 64'(busy_o), 64'd1);
      chk("op1_hold", mul_op1, a);
      @(negedge clk);
      n++;
      started |= mul_start;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("resp_data", resp_data, exp_d);
    chk("resp_err", 64'(resp_err), 64'(exp_e));
    chk("resp_rd", 64'(resp_rd), 64'(rd));
    chk("op_f3_hold", 64'(mul_op_f3), 64'(f));
    chk("op2_hold", mul_op2, b);
    chk("start_seen", 64'(started), 64'(op_supported(f) && a != 0 && b != 0));
    req_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_data", resp_data, exp_d);
      chk("hold_rd", 64'(resp_rd), 64'(rd));
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_start", 64'(mul_start), 64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("valid_clr", 64'(resp_valid), 64'd0);
    chk("busy_clr", 64'(busy_o), 64'd0);
    chk("ready_back", 64'(req_ready), 64'd1);
    chk("no_done_accept", mul_op1, a);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_start"}, 64'(mul_start), 64'd0);
    chk({tag, "_data"}, resp_data, 64'd0);
    chk({tag, "_rd"}, 64'(resp_rd), 64'd0);
    chk({tag, "_opf3"}, 64'(mul_op_f3), 64'd0);
    chk({tag, "_op1"}, mul_op1, 64'd0);
    chk({tag, "_op2"}, mul_op2, 64'd0);
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL global_timeout: bench did not reach its end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    logic [9:0]  f;
    logic [63:0] a, b;
    bit          en, gl;
    int          r;
    rst = 1'b1; req_valid = 1'b0; req_op_f3 = '0; req_op1 = '0; req_op2 = '0;
    req_rd = '0; flush = 1'b0; resp_ready = 1'b0;
    mul_finish = 1'b0; mul_product = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    do_op(INST_MUL, 64'd3, 64'd5, 5'd7, 0, 1'b0, 1'b1);
    do_op(INST_MULW, 64'h7FFF_FFFF, 64'd2, 5'd9, 0, 1'b0, 1'b1);
    do_op(INST_MULHU, '1, '1, 5'd31, 1, 1'b0, 1'b1);
    do_op(INST_MUL, 64'd0, 64'h1234, 5'd4, 0, 1'b0, 1'b1);
    do_op(10'b0110011100, 64'd6, 64'd7, 5'd5, 0, 1'b0, 1'b1);
    do_op(INST_MULH, 64'hFFFF_FFFF_FFFF_FFFD, 64'd100, 5'd12, 10, 1'b0, 1'b1);
    do_op(INST_MUL, 64'd21, 64'h80, 5'd3, 0, 1'b1, 1'b1);
    do_op(INST_MUL, 64'd5, 64'd9, 5'd17, 0, 1'b0, 1'b0);

    // Flush on the 5th RUN cycle, then a clean reload.
    stub_lat = 40; stub_en = 1'b1; stub_glitch = 1'b0;
    accept(INST_MUL, 64'd7, 64'd9, 5'd1);
    repeat (4) @(negedge clk);
    chk("flush_in_run", 64'(mul_start), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", 64'(resp_valid), 64'd0);
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_start", 64'(mul_start), 64'd0);
    chk("flush_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("flush_no_resp", 64'(resp_valid), 64'd0);
    do_op(INST_MUL, 64'd2, 64'd3, 5'd2, 0, 1'b0, 1'b1);

    // Flush in DONE drops the response.
    accept(INST_MUL, 64'd0, 64'd5, 5'd6);
    chk("done_valid", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush_valid", 64'(resp_valid), 64'd0);
    chk("done_flush_busy", 64'(busy_o), 64'd0);

    // Reset mid-RUN.
    stub_lat = 40;
    accept(INST_MUL, 64'd11, 64'd13, 5'd8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_no_resp", 64'(resp_valid), 64'd0);

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: f = INST_MUL;
        1: f = INST_MULH;
        2: f = INST_MULHSU;
        3: f = INST_MULHU;
        4: f = INST_MULW;
        5: f = 10'($urandom);
        default: f = INST_MUL;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? 64'd0 :
          ($urandom_range(0, 2) == 0) ? 64'($urandom_range(1, 255)) : {$urandom, $urandom};
      en = ($urandom_range(0, 11) != 0);
      gl = ($urandom_range(0, 3) == 0);
      do_op(f, a, b, 5'($urandom), int'($urandom_range(0, 3)), gl, en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
